// File: rtl/arcade_cen_gen.sv
// Fractional clock-enable generator: NUM_CH independent NUM/DEN accumulators, each emitting
// positive-phase (wrap) and negative-phase (half-point) pulses. Define ARCADE_CEN_GEN_PAUSE_EN for pause logic.
module arcade_cen_gen #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 8
) (
  input  logic                    I_CLK,
  input  logic                    I_RST,
  input  logic [NUM_CH*ACC_W-1:0] I_NUM,
  input  logic [NUM_CH*ACC_W-1:0] I_DEN,
  input  logic                    I_LOAD,
  input  logic                    I_PAUSE,
  input  logic [NUM_CH-1:0]       I_PAUSE_MASK,
  output logic [NUM_CH-1:0]       O_CENP,
  output logic [NUM_CH-1:0]       O_CENN,
  output logic [NUM_CH-1:0]       O_CFG_ERR
);

  logic [ACC_W-1:0]  r_num [NUM_CH];
  logic [ACC_W-1:0]  r_den [NUM_CH];
  logic [ACC_W-1:0]  r_acc [NUM_CH];
  logic [NUM_CH-1:0] r_err;
  logic [NUM_CH-1:0] r_cenp;
  logic [NUM_CH-1:0] r_cenn;

  logic [ACC_W:0]    w_sum     [NUM_CH];
  logic [ACC_W:0]    w_diff    [NUM_CH];
  logic [ACC_W-1:0]  w_half    [NUM_CH];
  logic [ACC_W-1:0]  w_acc_nxt [NUM_CH];
  logic [ACC_W-1:0]  w_ld_num  [NUM_CH];
  logic [ACC_W-1:0]  w_ld_den  [NUM_CH];
  logic [NUM_CH-1:0] w_ld_err;
  logic [NUM_CH-1:0] w_active;
  logic [NUM_CH-1:0] w_wrap;
  logic [NUM_CH-1:0] w_p_nxt;
  logic [NUM_CH-1:0] w_n_nxt;
  logic [NUM_CH-1:0] w_pause;

`ifdef ARCADE_CEN_GEN_PAUSE_EN
  assign w_pause = I_PAUSE ? I_PAUSE_MASK : '0;
`else
  logic w_unused_pause;
  assign w_unused_pause = ^{I_PAUSE, I_PAUSE_MASK};
  assign w_pause        = '0;
`endif

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_ld_num[c]  = I_NUM[c*ACC_W +: ACC_W];
      w_ld_den[c]  = I_DEN[c*ACC_W +: ACC_W];
      // 2*NUM evaluated one bit wider so the shift cannot overflow
      w_ld_err[c]  = (w_ld_den[c] == '0) || ({w_ld_num[c], 1'b0} > {1'b0, w_ld_den[c]});
      w_sum[c]     = {1'b0, r_acc[c]} + {1'b0, r_num[c]};
      w_diff[c]    = w_sum[c] - {1'b0, r_den[c]};
      w_half[c]    = r_den[c] >> 1;
      w_active[c]  = !r_err[c] && !w_pause[c] && (r_num[c] != '0);
      w_wrap[c]    = w_sum[c] >= {1'b0, r_den[c]};
      w_acc_nxt[c] = r_acc[c];
      if (w_active[c]) w_acc_nxt[c] = w_wrap[c] ? w_diff[c][ACC_W-1:0] : w_sum[c][ACC_W-1:0];
      w_p_nxt[c]   = w_active[c] && w_wrap[c];
      w_n_nxt[c]   = w_active[c] && !w_wrap[c] && (r_acc[c] < w_half[c]) &&
                     (w_sum[c] >= {1'b0, w_half[c]});
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_num[c] <= '0;
        r_den[c] <= '0;
        r_acc[c] <= '0;
      end
      r_err  <= '1;
      r_cenp <= '0;
      r_cenn <= '0;
    end else if (I_LOAD) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_num[c] <= w_ld_num[c];
        r_den[c] <= w_ld_den[c];
        r_acc[c] <= '0;
      end
      r_err  <= w_ld_err;
      r_cenp <= '0;
      r_cenn <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) r_acc[c] <= w_acc_nxt[c];
      r_cenp <= w_p_nxt;
      r_cenn <= w_n_nxt;
    end
  end

  assign O_CENP    = r_cenp;
  assign O_CENN    = r_cenn;
  assign O_CFG_ERR = r_err;

endmodule

// File: tb/tb_arcade_cen_gen.sv
// Self-checking bench for arcade_cen_gen: step-count reference model plus directed literal checks.
module tb_arcade_cen_gen;
  localparam int NUM_CH = 4;
  localparam int ACC_W  = 8;

  logic                    I_CLK = 1'b0;
  logic                    I_RST = 1'b1;
  logic [NUM_CH*ACC_W-1:0] I_NUM = '0;
  logic [NUM_CH*ACC_W-1:0] I_DEN = '0;
  logic                    I_LOAD = 1'b0;
  logic                    I_PAUSE = 1'b0;
  logic [NUM_CH-1:0]       I_PAUSE_MASK = '0;
  logic [NUM_CH-1:0]       O_CENP, O_CENN, O_CFG_ERR;

  arcade_cen_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_NUM(I_NUM), .I_DEN(I_DEN), .I_LOAD(I_LOAD),
    .I_PAUSE(I_PAUSE), .I_PAUSE_MASK(I_PAUSE_MASK),
    .O_CENP(O_CENP), .O_CENN(O_CENN), .O_CFG_ERR(O_CFG_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: channel c has taken m_n active steps since its last load, so the
  // phase is (m_n*NUM) mod DEN and the wrap count is floor(m_n*NUM/DEN).
  longint m_num [NUM_CH];
  longint m_den [NUM_CH];
  longint m_n   [NUM_CH];
  bit     m_err [NUM_CH];
  logic [NUM_CH-1:0] e_p = '0, e_n = '0, e_err = '1;

  always @(posedge I_CLK) begin
    if (I_RST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_num[c] = 0; m_den[c] = 0; m_n[c] = 0; m_err[c] = 1'b1;
      end
      e_p = '0; e_n = '0; e_err = '1;
    end else if (I_LOAD) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_num[c] = longint'(I_NUM[c*ACC_W +: ACC_W]);
        m_den[c] = longint'(I_DEN[c*ACC_W +: ACC_W]);
        m_err[c] = (m_den[c] == 0) || (2 * m_num[c] > m_den[c]);
        m_n[c]   = 0;
        e_err[c] = m_err[c];
      end
      e_p = '0; e_n = '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        bit paused;
        longint prev, half;
        paused = 1'b0;
`ifdef ARCADE_CEN_GEN_PAUSE_EN
        paused = I_PAUSE && I_PAUSE_MASK[c];
`endif
        if (!m_err[c] && m_num[c] != 0 && !paused) begin
          m_n[c]++;
          prev   = ((m_n[c] - 1) * m_num[c]) % m_den[c];
          half   = m_den[c] / 2;
          e_p[c] = ((m_n[c] * m_num[c]) / m_den[c]) != (((m_n[c] - 1) * m_num[c]) / m_den[c]);
          e_n[c] = !e_p[c] && (prev < half) && (prev + m_num[c] >= half);
        end else begin
          e_p[c] = 1'b0;
          e_n[c] = 1'b0;
        end
      end
    end
  end

  always @(negedge I_CLK) begin
    if (chk_en) begin
      check("cenp_vs_model", O_CENP, e_p);
      check("cenn_vs_model", O_CENN, e_n);
      check("cfg_err_vs_model", O_CFG_ERR, e_err);
      check("cenp_cenn_disjoint", O_CENP & O_CENN, '0);
    end
  end

  task automatic do_load(input logic [NUM_CH*ACC_W-1:0] num, input logic [NUM_CH*ACC_W-1:0] den);
    I_NUM = num; I_DEN = den; I_LOAD = 1'b1;
    @(negedge I_CLK);
    I_LOAD = 1'b0;
  endtask

  initial begin
    logic [11:0] n0, p0, n3, p3;
    logic [35:0] p2;
    int cnt1, consec, any2;
    bit prev1;

    // Reset
    @(negedge I_CLK);
    chk_en = 1'b1;
    @(negedge I_CLK);
    check("reset_cfg_err", O_CFG_ERR, 4'hF);
    check("reset_cenp", O_CENP, 4'h0);
    check("reset_cenn", O_CENN, 4'h0);
    I_RST = 1'b0;

    // ch0 1/4, ch1 11/48, ch2 3/4 (illegal), ch3 2/4
    do_load({8'd2, 8'd3, 8'd11, 8'd1}, {8'd4, 8'd4, 8'd48, 8'd4});
    check("load_cfg_err", O_CFG_ERR, 4'b0100);
    n0 = '0; p0 = '0; n3 = '0; p3 = '0;
    cnt1 = 0; consec = 0; any2 = 0; prev1 = 1'b0;
    for (int k = 1; k <= 4800; k++) begin
      @(negedge I_CLK);
      if (k <= 12) begin
        n0[k-1] = O_CENN[0]; p0[k-1] = O_CENP[0];
        n3[k-1] = O_CENN[3]; p3[k-1] = O_CENP[3];
      end
      if (O_CENP[1]) cnt1++;
      if (O_CENP[1] && prev1) consec++;
      prev1 = O_CENP[1];
      if (O_CENP[2] || O_CENN[2]) any2++;
    end
    check("ch0_cenn_pattern", n0, 12'h222);
    check("ch0_cenp_pattern", p0, 12'h888);
    check("ch3_cenn_alt", n3, 12'h555);
    check("ch3_cenp_alt", p3, 12'hAAA);
    check("ch1_pulse_count", cnt1, 1100);
    check("ch1_no_consecutive", consec, 0);
    check("ch2_err_silent", any2, 0);

    // Reload ch2 with a legal 1/12
    do_load({8'd2, 8'd1, 8'd11, 8'd1}, {8'd4, 8'd12, 8'd48, 8'd4});
    check("reload_cfg_err", O_CFG_ERR, 4'b0000);
    p2 = '0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge I_CLK);
      p2[k-1] = O_CENP[2];
    end
    check("ch2_cenp_every_12", p2, 36'h8_0080_0800);

`ifdef ARCADE_CEN_GEN_PAUSE_EN
    begin
      logic [3:0] rn, rp;
      int during;
      do_load({8'd2, 8'd1, 8'd11, 8'd1}, {8'd4, 8'd12, 8'd48, 8'd4});
      @(negedge I_CLK);  // ch0 ACC now 1
      I_PAUSE = 1'b1; I_PAUSE_MASK = 4'b0001;
      during = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge I_CLK);
        if (O_CENP[0] || O_CENN[0]) during++;
      end
      I_PAUSE = 1'b0;
      check("pause_ch0_silent", during, 0);
      rn = '0; rp = '0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge I_CLK);
        rn[k-1] = O_CENN[0]; rp[k-1] = O_CENP[0];
      end
      check("resume_cenn_1", rn, 4'b0001);
      check("resume_cenp_3", rp, 4'b0100);
      I_PAUSE_MASK = '0;
    end
`endif

    // Reset and load together: reset wins
    I_RST = 1'b1; I_LOAD = 1'b1;
    I_NUM = {8'd1, 8'd1, 8'd1, 8'd1}; I_DEN = {8'd4, 8'd4, 8'd4, 8'd4};
    @(negedge I_CLK);
    I_RST = 1'b0; I_LOAD = 1'b0;
    check("rst_load_cfg_err", O_CFG_ERR, 4'hF);
    begin
      int any;
      any = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge I_CLK);
        if ((O_CENP | O_CENN) != '0) any++;
      end
      check("rst_load_silent_20", any, 0);
    end

    // Randomized configurations, pauses and occasional resets
    for (int it = 0; it < 40; it++) begin
      logic [NUM_CH*ACC_W-1:0] rn, rd;
      int len;
      for (int c = 0; c < NUM_CH; c++) begin
        int d, n;
        d = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(255, 1);
        n = ($urandom_range(4, 0) == 0) ? $urandom_range(255, 0) : $urandom_range(d / 2, 0);
        rn[c*ACC_W +: ACC_W] = 8'(n);
        rd[c*ACC_W +: ACC_W] = 8'(d);
      end
      I_PAUSE_MASK = 4'($urandom_range(15, 0));
      do_load(rn, rd);
      len = $urandom_range(300, 50);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(7, 0) == 0) I_PAUSE = ~I_PAUSE;
        if ($urandom_range(199, 0) == 0) I_RST = 1'b1;
        @(negedge I_CLK);
        I_RST = 1'b0;
      end
    end
    I_PAUSE = 1'b0;
    @(negedge I_CLK);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
